// File: rtl/cram_bitstream_loader_if.sv
// Bitstream word handshake between the host feeder and the CRAM loader.
interface cram_bitstream_loader_if #(
   parameter int WORD_WIDTH = 8
) ();
   logic [WORD_WIDTH-1:0] word_in;
   logic                  word_valid;
   logic                  word_ready;

   modport master (
      output word_in,
      output word_valid,
      input  word_ready
   );

   modport slave (
      input  word_in,
      input  word_valid,
      output word_ready
   );
endinterface

// File: rtl/cram_bitstream_loader.sv
// Serializes bitstream words MSB-first into the CRAM shift chain and
// folds the bits returning from the chain tail into a parity.
module cram_bitstream_loader #(
   parameter int WORD_WIDTH   = 8,
   parameter int CHAIN_LENGTH = 1024,
   parameter int CNT_WIDTH    = $clog2(CHAIN_LENGTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   cram_bitstream_loader_if.slave wif,
   output logic                 cfg_data,
   output logic                 cfg_en,
   input  logic                 cfg_data_ret,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] bits_loaded,
   output logic                 prev_parity
);

   localparam int NBW = $clog2(WORD_WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [WORD_WIDTH-1:0] shift_q, shift_d;
   logic [NBW-1:0]        nbits_q, nbits_d;
   logic [CNT_WIDTH-1:0]  bits_q, bits_d;
   logic                  par_q, par_d;
   logic                  done_q, done_d;
   logic                  rdy_q, rdy_d;
   logic                  data_q, data_d;
   logic                  en_q, en_d;
   logic                  busy_q, busy_d;
   logic [31:0]           left;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      nbits_d = nbits_q;
      bits_d  = bits_q;
      par_d   = par_q;
      done_d  = done_q;
      // chain bits still to go; clips the final partial word
      left    = 32'(CHAIN_LENGTH) - 32'(bits_q);
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start && !abort) begin
               state_d = S_LOAD;
               bits_d  = '0;
               par_d   = 1'b0;
               done_d  = 1'b0;
            end
         end
         S_LOAD: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (wif.word_valid) begin
               shift_d = wif.word_in;
               state_d = S_SHIFT;
               if (left < 32'(WORD_WIDTH)) begin
                  nbits_d = NBW'(left);
               end else begin
                  nbits_d = NBW'(WORD_WIDTH);
               end
            end
         end
         S_SHIFT: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               shift_d = shift_q << 1;
               nbits_d = nbits_q - NBW'(1);
               bits_d  = bits_q + CNT_WIDTH'(1);
               par_d   = par_q ^ cfg_data_ret;
               if (nbits_q == NBW'(1)) begin
                  if (bits_q == CNT_WIDTH'(CHAIN_LENGTH - 1)) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_LOAD;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // outputs registered from the next state so they line up with it
      rdy_d  = (state_d == S_LOAD);
      en_d   = (state_d == S_SHIFT);
      busy_d = rdy_d || en_d;
      data_d = en_d && shift_d[WORD_WIDTH-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         nbits_q <= '0;
         bits_q  <= '0;
         par_q   <= 1'b0;
         done_q  <= 1'b0;
         rdy_q   <= 1'b0;
         data_q  <= 1'b0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         nbits_q <= nbits_d;
         bits_q  <= bits_d;
         par_q   <= par_d;
         done_q  <= done_d;
         rdy_q   <= rdy_d;
         data_q  <= data_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
      end
   end

   assign wif.word_ready = rdy_q;
   assign cfg_data       = data_q;
   assign cfg_en         = en_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign bits_loaded    = bits_q;
   assign prev_parity    = par_q;

endmodule

// File: tb/tb_cram_bitstream_loader.sv
// Directed bench: a 20-bit chain loader and a 16-bit chain loader,
// each with a behavioural chain model on the tail.
module tb_cram_bitstream_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, abort, sel;
   logic [7:0] word_in;
   logic       word_valid;
   logic       pre_a, pre_b;
   logic [19:0] pre_val;

   cram_bitstream_loader_if #(.WORD_WIDTH(8)) wa ();
   cram_bitstream_loader_if #(.WORD_WIDTH(8)) wb ();

   assign wa.word_in    = word_in;
   assign wb.word_in    = word_in;
   assign wa.word_valid = word_valid & ~sel;
   assign wb.word_valid = word_valid & sel;

   logic       data_a, en_a, busy_a, done_a, par_a, ret_a;
   logic       data_b, en_b, busy_b, done_b, par_b, ret_b;
   logic [4:0] bits_a, bits_b;
   logic [19:0] chain_a;
   logic [15:0] chain_b;

   assign ret_a = chain_a[19];
   assign ret_b = chain_b[15];

   cram_bitstream_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(20)) dut_a (
      .clk(clk), .rst(rst), .start(start & ~sel), .abort(abort & ~sel),
      .wif(wa), .cfg_data(data_a), .cfg_en(en_a), .cfg_data_ret(ret_a),
      .busy(busy_a), .done(done_a), .bits_loaded(bits_a),
      .prev_parity(par_a)
   );

   cram_bitstream_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(16)) dut_b (
      .clk(clk), .rst(rst), .start(start & sel), .abort(abort & sel),
      .wif(wb), .cfg_data(data_b), .cfg_en(en_b), .cfg_data_ret(ret_b),
      .busy(busy_b), .done(done_b), .bits_loaded(bits_b),
      .prev_parity(par_b)
   );

   // chain models shift on the same edge the loader counts the bit
   always @(posedge clk) begin
      if (pre_a) chain_a <= pre_val;
      else if (en_a) chain_a <= {chain_a[18:0], data_a};
      if (pre_b) chain_b <= pre_val[15:0];
      else if (en_b) chain_b <= {chain_b[14:0], data_b};
   end

   logic       rdy, data, en, busy, done, par;
   logic [4:0] bits;
   assign rdy  = sel ? wb.word_ready : wa.word_ready;
   assign data = sel ? data_b : data_a;
   assign en   = sel ? en_b : en_a;
   assign busy = sel ? busy_b : busy_a;
   assign done = sel ? done_b : done_a;
   assign par  = sel ? par_b : par_a;
   assign bits = sel ? bits_b : bits_a;

   int          nen = 0, nlow = 0, nz = 0;
   logic [31:0] rec = '0;
   logic        prev_en = 1'b0, fall_done = 1'b0;

   always @(negedge clk) begin
      if (en) begin
         rec = {rec[30:0], data};
         nen++;
      end else if (data) begin
         nz++;
      end
      if (busy && !en) nlow++;
      if (prev_en && !en) fall_done = done;
      prev_en = en;
   end

   int nvec = 0, nerr = 0;
   int b0, l0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic preload(input logic [19:0] v);
      pre_val = v;
      if (sel) pre_b = 1'b1;
      else pre_a = 1'b1;
      @(negedge clk);
      pre_a = 1'b0;
      pre_b = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w, input int gap);
      int n = 0;
      while (!rdy && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rdy_wait", 32'(rdy), 32'd1);
      repeat (gap) @(negedge clk);
      word_in    = w;
      word_valid = 1'b1;
      @(negedge clk);
      word_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("done_wait", 32'(done), 32'd1);
      #1;
   endtask

   task automatic load3(input int gap);
      do_start();
      send_word(8'hA5, 0);
      send_word(8'h3C, gap);
      send_word(8'hF0, gap);
      wait_done();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; sel = 1'b0;
      word_in = '0; word_valid = 1'b0;
      pre_a = 1'b0; pre_b = 1'b0; pre_val = '0;
      repeat (2) @(negedge clk);
      check("rst_a", 32'({wa.word_ready, data_a, en_a, busy_a, done_a,
                          par_a, bits_a}), 32'd0);
      check("rst_b", 32'({wb.word_ready, data_b, en_b, busy_b, done_b,
                          par_b, bits_b}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // basic load, tail preloaded with all ones
      preload(20'hFFFFF);
      b0 = nen; l0 = nlow;
      load3(0);
      check("t1_stream", 32'(rec[19:0]), 32'hA53CF);
      check("t1_en_cnt", 32'(nen - b0), 32'd20);
      check("t1_low_cnt", 32'(nlow - l0), 32'd3);
      check("t1_done_lag", 32'(fall_done), 32'd1);
      check("t1_status", 32'({rdy, busy, bits}), 32'd20);
      check("t2_parity", 32'(par), 32'd0);
      check("t2_chain", 32'(chain_a), 32'hA53CF);

      // 5-cycle starvation between words
      b0 = nen; l0 = nlow;
      load3(5);
      check("t3_stream", 32'(rec[19:0]), 32'hA53CF);
      check("t3_en_cnt", 32'(nen - b0), 32'd20);
      check("t3_low_cnt", 32'(nlow - l0), 32'd13);
      check("t3_par_bits", 32'({par, bits}), 32'd20);

      // abort on third shift cycle of word 2
      do_start();
      send_word(8'hA5, 0);
      send_word(8'h3C, 0);
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t4_abort", 32'({busy, en, done, rdy, bits}), 32'd10);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      repeat (2) @(negedge clk);
      check("t4_hold", 32'({busy, en, done, bits}), 32'd10);
      preload(20'h00001);
      b0 = nen;
      load3(0);
      check("t4_stream", 32'(rec[19:0]), 32'hA53CF);
      check("t4_en_cnt", 32'(nen - b0), 32'd20);
      check("t4_par_bits", 32'({par, bits}), 32'h34);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);
      check("t4_done_abort", 32'({done, bits}), 32'h34);

      // async reset mid-shift
      do_start();
      send_word(8'hA5, 0);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check("t5_rst", 32'({rdy, data, en, busy, done, par, bits}),
               32'd0);
      @(negedge clk);
      rst = 1'b0;
      preload(20'h80000);
      b0 = nen;
      load3(0);
      check("t5_stream", 32'(rec[19:0]), 32'hA53CF);
      check("t5_en_cnt", 32'(nen - b0), 32'd20);
      check("t5_par_bits", 32'({par, bits}), 32'h34);

      // 16-bit chain: two loads, start while busy ignored
      @(negedge clk);
      sel = 1'b1;
      preload(20'h00007);
      b0 = nen;
      do_start();
      send_word(8'hC3, 0);
      send_word(8'h5A, 0);
      wait_done();
      check("t6_stream1", 32'(rec[15:0]), 32'hC35A);
      check("t6_en_cnt1", 32'(nen - b0), 32'd16);
      check("t6_par_bits1", 32'({par, bits}), 32'h30);
      do_start();
      check("t6_restart", 32'({done, bits, par, busy, rdy}), 32'd3);
      b0 = nen;
      send_word(8'h81, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t6_mid_start", 32'({busy, en, bits}), 32'h61);
      send_word(8'h7E, 0);
      wait_done();
      check("t6_stream2", 32'(rec[15:0]), 32'h817E);
      check("t6_en_cnt2", 32'(nen - b0), 32'd16);
      check("t6_par_bits2", 32'({par, bits}), 32'h10);
      check("t6_chain", 32'(chain_b), 32'h817E);
      check("data_idle_zero", 32'(nz), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
